// File: rtl/wb_arbiter_pkg.sv
// Shared widths, constants and types for the writeback arbiter and its LSU buffer.
package wb_arbiter_pkg;

    localparam int REG_BUS       = 32;
    localparam int REG_ADDR_BUS  = 5;
    localparam int WB_ENTRY_W    = REG_ADDR_BUS + REG_BUS;
    localparam int WB_FIFO_DEPTH = 2;
    localparam int WB_STARVE_MAX = 4;

    localparam logic [REG_ADDR_BUS-1:0] ZERO_REG      = 5'd0;
    localparam logic [REG_BUS-1:0]      ZERO_WORD     = 32'd0;
    localparam logic                    REGWEN_ENABLE = 1'b1;

    typedef struct packed {
        logic [REG_ADDR_BUS-1:0] rd;
        logic [REG_BUS-1:0]      data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_FIFO = 2'd2
    } wb_sel_e;

    function automatic logic [REG_BUS-1:0] rd_onehot(input logic [REG_ADDR_BUS-1:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering {rd, data} LSU results; flags derive from the registered count.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  wb_entry_t din_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == {CNT_W{1'b0}});
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign head_o  = r_mem[r_rd_ptr];

    // Storage array; stale contents are harmless because the count gates every read.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU-priority selection onto the register-file write port,
// LSU result buffering, long-latency scoreboard and ALU starvation throttle.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int STARVE_MAX = WB_STARVE_MAX
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    alu_valid_i,
    input  logic [REG_ADDR_BUS-1:0] alu_rd_i,
    input  logic [REG_BUS-1:0]      alu_data_i,
    input  logic                    lsu_valid_i,
    output logic                    lsu_ready_o,
    input  logic [REG_ADDR_BUS-1:0] lsu_rd_i,
    input  logic [REG_BUS-1:0]      lsu_data_i,
    input  logic                    issue_valid_i,
    input  logic [REG_ADDR_BUS-1:0] issue_rd_i,
    output logic                    alu_stall_o,
    output logic [REG_BUS-1:0]      pending_o,
    output logic                    RegWEn_o,
    output logic [REG_ADDR_BUS-1:0] AddrD_o,
    output logic [REG_BUS-1:0]      DataD_o
);

    localparam int STV_W = $clog2(STARVE_MAX + 1);

    wb_entry_t               w_fifo_din;
    wb_entry_t               w_fifo_head;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_push;
    logic                    w_pop;
    wb_sel_e                 w_sel;
    logic                    w_sel_valid;
    logic [REG_ADDR_BUS-1:0] w_sel_rd;
    logic [REG_BUS-1:0]      w_sel_data;
    logic [REG_BUS-1:0]      w_pending_next;
    logic [STV_W-1:0]        w_starve_next;
    logic                    w_stall_next;

    logic [REG_BUS-1:0]      r_pending;
    logic [STV_W-1:0]        r_starve_cnt;
    logic                    r_alu_stall;
    logic                    r_wen;
    logic [REG_ADDR_BUS-1:0] r_addr;
    logic [REG_BUS-1:0]      r_data;

    assign lsu_ready_o = !w_fifo_full;
    assign w_push      = lsu_valid_i && lsu_ready_o;
    assign w_pop       = (w_sel == SEL_FIFO);
    assign w_fifo_din  = '{rd: lsu_rd_i, data: lsu_data_i};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_fifo_din),
        .head_o  (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Source selection: the ALU always wins, even while a stall is being requested.
    always_comb begin
        w_sel = SEL_NONE;
        if (alu_valid_i) begin
            w_sel = SEL_ALU;
        end else if (!w_fifo_empty) begin
            w_sel = SEL_FIFO;
        end else begin
            w_sel = SEL_NONE;
        end
    end

    // Write-port mux for the selected source.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rd    = ZERO_REG;
        w_sel_data  = ZERO_WORD;
        case (w_sel)
            SEL_ALU: begin
                w_sel_valid = 1'b1;
                w_sel_rd    = alu_rd_i;
                w_sel_data  = alu_data_i;
            end
            SEL_FIFO: begin
                w_sel_valid = 1'b1;
                w_sel_rd    = w_fifo_head.rd;
                w_sel_data  = w_fifo_head.data;
            end
            default: begin
                w_sel_valid = 1'b0;
            end
        endcase
    end

    // Scoreboard update: clear on FIFO retire first so a same-cycle issue wins.
    always_comb begin
        w_pending_next = r_pending;
        if (w_pop) begin
            w_pending_next = w_pending_next & ~rd_onehot(w_fifo_head.rd);
        end else begin
            w_pending_next = w_pending_next;
        end
        if (issue_valid_i && (issue_rd_i != ZERO_REG)) begin
            w_pending_next = w_pending_next | rd_onehot(issue_rd_i);
        end else begin
            w_pending_next = w_pending_next;
        end
        w_pending_next[0] = 1'b0;
    end

    // Starvation count: ALU wins while the FIFO waits; hitting the limit requests one stall.
    always_comb begin
        w_starve_next = {STV_W{1'b0}};
        if (alu_valid_i && !w_fifo_empty) begin
            w_starve_next = r_starve_cnt + 1'b1;
        end else begin
            w_starve_next = {STV_W{1'b0}};
        end
        w_stall_next = (w_starve_next == STV_W'(STARVE_MAX));
    end

    // Scoreboard and starvation state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending    <= ZERO_WORD;
            r_starve_cnt <= {STV_W{1'b0}};
            r_alu_stall  <= 1'b0;
        end else begin
            r_pending    <= w_pending_next;
            r_alu_stall  <= w_stall_next;
            r_starve_cnt <= w_stall_next ? {STV_W{1'b0}} : w_starve_next;
        end
    end

    // Write-port registers; address and data hold when nothing is selected.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wen  <= 1'b0;
            r_addr <= ZERO_REG;
            r_data <= ZERO_WORD;
        end else if (w_sel_valid) begin
            r_wen  <= (w_sel_rd != ZERO_REG) ? REGWEN_ENABLE : ~REGWEN_ENABLE;
            r_addr <= w_sel_rd;
            r_data <= w_sel_data;
        end else begin
            r_wen  <= ~REGWEN_ENABLE;
        end
    end

    assign pending_o   = r_pending;
    assign alu_stall_o = r_alu_stall;
    assign RegWEn_o    = r_wen;
    assign AddrD_o     = r_addr;
    assign DataD_o     = r_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU vector table plus hand-written multi-cycle sequences.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        alu_stall_o;
    logic [31:0] pending_o;
    logic        RegWEn_o;
    logic [4:0]  AddrD_o;
    logic [31:0] DataD_o;

    int total = 0;
    int bad   = 0;
    logic illegal_seen = 1'b0;

    wb_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .alu_valid_i   (alu_valid_i),
        .alu_rd_i      (alu_rd_i),
        .alu_data_i    (alu_data_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_rd_i      (lsu_rd_i),
        .lsu_data_i    (lsu_data_i),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .alu_stall_o   (alu_stall_o),
        .pending_o     (pending_o),
        .RegWEn_o      (RegWEn_o),
        .AddrD_o       (AddrD_o),
        .DataD_o       (DataD_o)
    );

    always #5 clk = ~clk;

    // Issuing to a register that is already pending is illegal upstream behaviour.
    always @(posedge clk) begin
        if (!rst_i && issue_valid_i && issue_rd_i != 5'd0 && pending_o[issue_rd_i])
            illegal_seen <= 1'b1;
    end

    typedef struct {
        logic        av;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        ewen;
        logic [4:0]  eaddr;
        logic [31:0] edata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic iv, input logic [4:0] ird);
        alu_valid_i   = av;
        alu_rd_i      = ard;
        alu_data_i    = ad;
        lsu_valid_i   = lv;
        lsu_rd_i      = lrd;
        lsu_data_i    = ld;
        issue_valid_i = iv;
        issue_rd_i    = ird;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic chk_wr(input string name, input logic wen, input logic [4:0] addr,
                          input logic [31:0] data);
        chk({name, "_wen"}, 32'(RegWEn_o), 32'(wen));
        chk({name, "_addr"}, 32'(AddrD_o), 32'(addr));
        chk({name, "_data"}, DataD_o, data);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd0,  32'h11111111};
        vecs[2] = '{1'b0, 5'd3,  32'h22222222, 1'b0, 5'd0,  32'h11111111};
        vecs[3] = '{1'b1, 5'd31, 32'h00000000, 1'b1, 5'd31, 32'h00000000};
        vecs[4] = '{1'b1, 5'd1,  32'hFFFFFFFF, 1'b1, 5'd1,  32'hFFFFFFFF};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd1,  32'hFFFFFFFF};

        rst_i = 1'b1;
        idle();
        step();
        step();
        rst_i = 1'b0;
        chk_wr("reset", 1'b0, 5'd0, 32'd0);
        chk("reset_pending", pending_o, 32'd0);
        chk("reset_stall", 32'(alu_stall_o), 32'd0);
        chk("reset_ready", 32'(lsu_ready_o), 32'd1);

        // ALU-only vectors, FIFO empty
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].av, vecs[i].rd, vecs[i].d, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            step();
            chk_wr($sformatf("vec%0d", i), vecs[i].ewen, vecs[i].eaddr, vecs[i].edata);
        end

        // Scoreboard round trip on x7
        idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        step();
        chk("pend7_set", 32'(pending_o[7]), 32'd1);
        idle();
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
        chk("lsu7_ready", 32'(lsu_ready_o), 32'd1);
        step();
        idle();
        chk("pend7_hold", 32'(pending_o[7]), 32'd1);
        chk("lsu7_nowr", 32'(RegWEn_o), 32'd0);
        step();
        chk_wr("lsu7", 1'b1, 5'd7, 32'h1234);
        chk("pend7_clr", 32'(pending_o[7]), 32'd0);

        // Backpressure: three LSU results against a busy ALU
        drive(1'b1, 5'd2, 32'hA0, 1'b1, 5'd10, 32'hB1, 1'b0, 5'd0);
        chk("bp_ready0", 32'(lsu_ready_o), 32'd1);
        step();
        chk_wr("bp_alu0", 1'b1, 5'd2, 32'hA0);
        drive(1'b1, 5'd3, 32'hA1, 1'b1, 5'd11, 32'hB2, 1'b0, 5'd0);
        chk("bp_ready1", 32'(lsu_ready_o), 32'd1);
        step();
        chk_wr("bp_alu1", 1'b1, 5'd3, 32'hA1);
        chk("bp_full", 32'(lsu_ready_o), 32'd0);
        drive(1'b1, 5'd4, 32'hA2, 1'b1, 5'd12, 32'hB3, 1'b0, 5'd0);
        step();
        chk_wr("bp_alu2", 1'b1, 5'd4, 32'hA2);
        chk("bp_still_full", 32'(lsu_ready_o), 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hB3, 1'b0, 5'd0);
        step();
        chk_wr("bp_lsu1", 1'b1, 5'd10, 32'hB1);
        chk("bp_ready_again", 32'(lsu_ready_o), 32'd1);
        step();
        idle();
        chk_wr("bp_lsu2", 1'b1, 5'd11, 32'hB2);
        step();
        chk_wr("bp_lsu3", 1'b1, 5'd12, 32'hB3);
        step();
        chk("bp_drained", 32'(RegWEn_o), 32'd0);
        chk("bp_stall", 32'(alu_stall_o), 32'd0);

        // Starvation: one buffered entry, ALU valid every cycle
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hC4, 1'b0, 5'd0);
        step();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 5'd14, 32'(k), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            step();
            chk($sformatf("starve_stall%0d", k), 32'(alu_stall_o), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("starve_wr%0d", k), DataD_o, 32'(k));
        end
        idle();
        step();
        chk("starve_stall_end", 32'(alu_stall_o), 32'd0);
        chk_wr("starve_lsu", 1'b1, 5'd13, 32'hC4);
        step();
        chk("starve_once", 32'(alu_stall_o), 32'd0);

        // Same-cycle set and clear on x9: set wins
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hD5, 1'b0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        step();
        chk("pend9_setwins", 32'(pending_o[9]), 32'd1);
        chk_wr("lsu9a", 1'b1, 5'd9, 32'hD5);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hD6, 1'b0, 5'd0);
        step();
        idle();
        step();
        chk_wr("lsu9b", 1'b1, 5'd9, 32'hD6);
        chk("pend9_clr", 32'(pending_o[9]), 32'd0);

        // Reset mid-operation
        drive(1'b1, 5'd6, 32'hE0, 1'b1, 5'd21, 32'hF1, 1'b1, 5'd20);
        step();
        drive(1'b1, 5'd6, 32'hE1, 1'b1, 5'd22, 32'hF2, 1'b1, 5'd23);
        step();
        chk("pre_rst_pend", pending_o, 32'h00900000);
        chk("pre_rst_full", 32'(lsu_ready_o), 32'd0);
        rst_i = 1'b1;
        drive(1'b1, 5'd8, 32'hE2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        step();
        rst_i = 1'b0;
        idle();
        chk_wr("rst_mid", 1'b0, 5'd0, 32'd0);
        chk("rst_mid_pend", pending_o, 32'd0);
        chk("rst_mid_stall", 32'(alu_stall_o), 32'd0);
        chk("rst_mid_ready", 32'(lsu_ready_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rst_nowr%0d", k), 32'(RegWEn_o), 32'd0);
        end

        chk("illegal_issue", 32'(illegal_seen), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
